// File: rtl/frame_buffer.sv
// Double-buffered LED frame store: a host byte stream fills the back bank row by row
// while the display reads the front bank; banks swap only on a display frame boundary.
module frame_buffer #(
  parameter int ROWS         = 16,
  parameter int ROW_BITS     = 4,
  parameter int LEDS_PER_ROW = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        wr_sof,
  input  logic                        wr_valid,
  input  logic [7:0]                  wr_data,
  output logic                        wr_ready,
  input  logic                        frame_sync,
  input  logic [ROW_BITS-1:0]         row,
  output logic [24*LEDS_PER_ROW-1:0]  row_colors,
  output logic                        front_sel,
  output logic                        frame_swapped
);

  localparam int W     = 24 * LEDS_PER_ROW;
  localparam int BYTES = 3 * LEDS_PER_ROW;
  localparam int CNT_W = $clog2(BYTES);

  typedef enum logic [1:0] {FILL, COMMIT, WAIT_SWAP} state_t;

  state_t                state_reg;
  logic [CNT_W-1:0]      byte_cnt_reg;
  logic [ROW_BITS-1:0]   row_cnt_reg;
  logic [W-1:0]          asm_reg;
  logic [W-1:0]          row_colors_reg;
  logic                  front_sel_reg;
  logic                  wr_ready_reg;
  logic                  frame_swapped_reg;
  logic [2*ROWS-1:0]     row_valid_reg;
  logic [W-1:0]          bank [2*ROWS];

  logic [ROW_BITS:0]     rd_addr;
  logic [ROW_BITS:0]     wr_addr;
  logic                  transfer;
  logic                  last_byte;

  assign rd_addr   = {front_sel_reg, row};
  assign wr_addr   = {~front_sel_reg, row_cnt_reg};
  assign transfer  = wr_valid && wr_ready_reg;
  assign last_byte = (byte_cnt_reg == CNT_W'(BYTES - 1));

  assign wr_ready      = wr_ready_reg;
  assign row_colors    = row_colors_reg;
  assign front_sel     = front_sel_reg;
  assign frame_swapped = frame_swapped_reg;

  // Storage array has no reset; per-row valid bits make both banks read back as zero after reset.
  always_ff @(posedge clk) begin
    if (state_reg == COMMIT) begin
      bank[wr_addr] <= asm_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg         <= FILL;
      byte_cnt_reg      <= '0;
      row_cnt_reg       <= '0;
      asm_reg           <= '0;
      row_colors_reg    <= '0;
      front_sel_reg     <= 1'b0;
      wr_ready_reg      <= 1'b1;
      frame_swapped_reg <= 1'b0;
      row_valid_reg     <= '0;
    end else begin
      frame_swapped_reg <= 1'b0;
      row_colors_reg    <= row_valid_reg[rd_addr] ? bank[rd_addr] : '0;

      case (state_reg)
        FILL: begin
          if (wr_sof) begin
            // A byte arriving with the start strobe becomes byte 0 of row 0.
            row_cnt_reg <= '0;
            if (transfer) begin
              asm_reg      <= {asm_reg[W-9:0], wr_data};
              byte_cnt_reg <= CNT_W'(1);
            end else begin
              byte_cnt_reg <= '0;
            end
          end else if (transfer) begin
            asm_reg <= {asm_reg[W-9:0], wr_data};
            if (last_byte) begin
              state_reg    <= COMMIT;
              wr_ready_reg <= 1'b0;
            end else begin
              byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
          end
        end

        COMMIT: begin
          row_valid_reg[wr_addr] <= 1'b1;
          byte_cnt_reg           <= '0;
          if (wr_sof) begin
            row_cnt_reg  <= '0;
            state_reg    <= FILL;
            wr_ready_reg <= 1'b1;
          end else if (row_cnt_reg == ROW_BITS'(ROWS - 1)) begin
            state_reg <= WAIT_SWAP;
          end else begin
            row_cnt_reg  <= row_cnt_reg + 1'b1;
            state_reg    <= FILL;
            wr_ready_reg <= 1'b1;
          end
        end

        WAIT_SWAP: begin
          if (frame_sync) begin
            front_sel_reg     <= ~front_sel_reg;
            row_cnt_reg       <= '0;
            state_reg         <= FILL;
            wr_ready_reg      <= 1'b1;
            frame_swapped_reg <= 1'b1;
          end
        end

        default: begin
          state_reg    <= FILL;
          wr_ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer.sv
// Randomised bench for frame_buffer: byte-level frame model plus a cycle-stamped scoreboard
// drained by an independent monitor on the falling edge.
module tb_frame_buffer;

  localparam int ROWS         = 16;
  localparam int ROW_BITS     = 4;
  localparam int LEDS_PER_ROW = 16;
  localparam int W            = 24 * LEDS_PER_ROW;
  localparam int BYTES        = 3 * LEDS_PER_ROW;

  localparam int K_ROW   = 0;
  localparam int K_FRONT = 1;
  localparam int K_READY = 2;
  localparam int K_SWAP  = 3;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                wr_sof = 1'b0;
  logic                wr_valid = 1'b0;
  logic [7:0]          wr_data = '0;
  logic                wr_ready;
  logic                frame_sync = 1'b0;
  logic [ROW_BITS-1:0] rd_row = '0;
  logic [W-1:0]        row_colors;
  logic                front_sel;
  logic                frame_swapped;

  frame_buffer #(.ROWS(ROWS), .ROW_BITS(ROW_BITS), .LEDS_PER_ROW(LEDS_PER_ROW)) dut (
    .clk(clk), .reset_n(reset_n), .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_data(wr_data),
    .wr_ready(wr_ready), .frame_sync(frame_sync), .row(rd_row), .row_colors(row_colors),
    .front_sel(front_sel), .frame_swapped(frame_swapped)
  );

  always #5 clk = ~clk;

  int cycle_count = 0;
  always @(posedge clk) cycle_count <= cycle_count + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int           cyc;
    int           kind;
    logic [W-1:0] exp;
  } exp_t;
  exp_t sb_q[$];

  // Reference model: whole frames as byte lists, banks as finished row words.
  logic [W-1:0] m_bank [2][ROWS];
  logic [7:0]   m_bytes [BYTES];
  int           m_fs, m_row, m_byte;
  bit           m_full;

  function automatic void model_reset();
    for (int b = 0; b < 2; b++)
      for (int r = 0; r < ROWS; r++) m_bank[b][r] = '0;
    m_fs = 0; m_row = 0; m_byte = 0; m_full = 0;
  endfunction

  function automatic logic [W-1:0] build_row();
    logic [W-1:0] w = '0;
    for (int b = 0; b < BYTES; b++) w[W-1-8*b -: 8] = m_bytes[b];
    return w;
  endfunction

  function automatic void model_write(input logic [7:0] d, input bit sof);
    if (sof) begin m_row = 0; m_byte = 0; end
    m_bytes[m_byte] = d;
    m_byte++;
    if (m_byte == BYTES) begin
      m_bank[1-m_fs][m_row] = build_row();
      m_byte = 0;
      if (m_row == ROWS - 1) m_full = 1;
      else m_row++;
    end
  endfunction

  function automatic void push(input int cyc, input int kind, input logic [W-1:0] e);
    exp_t t;
    t.cyc = cyc; t.kind = kind; t.exp = e;
    sb_q.push_back(t);
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_ROW:   return "row_colors";
      K_FRONT: return "front_sel";
      K_READY: return "wr_ready";
      default: return "frame_swapped";
    endcase
  endfunction

  function automatic logic [W-1:0] actual(input int kind);
    case (kind)
      K_ROW:   return row_colors;
      K_FRONT: return W'(front_sel);
      K_READY: return W'(wr_ready);
      default: return W'(frame_swapped);
    endcase
  endfunction

  // Monitor: compares every expectation stamped for the current cycle.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cycle_count) begin
        checks++;
        if (sb_q[i].cyc < cycle_count || actual(sb_q[i].kind) !== sb_q[i].exp) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%h want=%h", kname(sb_q[i].kind), sb_q[i].cyc,
                   actual(sb_q[i].kind), sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic rand_read();
    rd_row = ROW_BITS'($urandom_range(ROWS - 1));
    push(cycle_count + 1, K_ROW, m_bank[m_fs][rd_row]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      rand_read();
      @(posedge clk); #1;
    end
  endtask

  task automatic write_byte(input logic [7:0] d, input bit sof);
    bit ok;
    int n;
    n = 0;
    wr_valid = 1'b1; wr_data = d; wr_sof = sof;
    do begin
      rand_read();
      ok = wr_ready;
      @(posedge clk); #1;
      wr_sof = 1'b0;
      n++;
    end while (!ok && n < 8);
    wr_valid = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL write_timeout got=wr_ready_low want=transfer within 8 cycles");
    end else begin
      model_write(d, sof);
      if (m_byte == 0) push(cycle_count, K_READY, '0);
    end
  endtask

  task automatic sync_pulse();
    logic [ROW_BITS-1:0] r;
    r = ROW_BITS'($urandom_range(ROWS - 1));
    rd_row = r; frame_sync = 1'b1;
    push(cycle_count + 1, K_ROW, m_bank[m_fs][r]);
    @(posedge clk); #1;
    frame_sync = 1'b0;
    if (m_full) begin
      m_fs = 1 - m_fs; m_full = 0; m_row = 0; m_byte = 0;
      push(cycle_count, K_SWAP, W'(1));
    end else begin
      push(cycle_count, K_SWAP, '0);
    end
    push(cycle_count, K_FRONT, W'(m_fs));
    push(cycle_count + 1, K_ROW, m_bank[m_fs][r]);
    @(posedge clk); #1;
    push(cycle_count, K_SWAP, '0);
    $display("sync: front_sel=%0d", m_fs);
  endtask

  task automatic sweep();
    for (int r = 0; r < ROWS; r++) begin
      rd_row = ROW_BITS'(r);
      push(cycle_count + 1, K_ROW, m_bank[m_fs][r]);
      push(cycle_count, K_FRONT, W'(m_fs));
      push(cycle_count, K_READY, W'(!m_full));
      @(posedge clk); #1;
    end
    $display("sweep: 16 rows read, front_sel=%0d", m_fs);
  endtask

  task automatic write_frame(input bit pattern, input bit mid_sync);
    for (int i = 0; i < ROWS * BYTES; i++) begin
      if (mid_sync && i == 5 * BYTES + 10) sync_pulse();
      write_byte(pattern ? 8'(i) : 8'($urandom), 1'b0);
    end
    $display("frame: %0d bytes written", ROWS * BYTES);
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    sweep();

    // Frame A: counting pattern, ignored sync while filling row 5
    write_frame(1'b1, 1'b1);
    idle(2);
    sync_pulse();
    sweep();

    // Frame B: restart after 100 bytes with 8'hAA as the new first byte
    for (int i = 0; i < 100; i++) write_byte(8'($urandom), 1'b0);
    write_byte(8'hAA, 1'b1);
    for (int i = 1; i < ROWS * BYTES; i++) write_byte(8'($urandom), 1'b0);
    idle(2);
    wr_valid = 1'b1; wr_sof = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'($urandom);
      push(cycle_count, K_READY, '0);
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; wr_sof = 1'b0;
    $display("wait_swap: 10 cycles of valid+sof held off");
    sync_pulse();
    sweep();

    // Frame C into bank 1, then reset during a row commit
    write_frame(1'b0, 1'b0);
    idle(2);
    sync_pulse();
    sweep();
    for (int i = 0; i < BYTES - 1; i++) write_byte(8'($urandom), 1'b0);
    wr_valid = 1'b1; wr_data = 8'h5C;
    @(posedge clk); #1;
    wr_valid = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    push(cycle_count, K_ROW, '0);
    push(cycle_count, K_FRONT, '0);
    push(cycle_count, K_READY, W'(1));
    push(cycle_count, K_SWAP, '0);
    $display("reset asserted during commit");
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    sweep();

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain got=%0d pending want=0 pending", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
